// File: rtl/dram_fill_check_if.sv
// RAM-side bus between the fill/check sequencer and a RAM32X1D-style
// dual-port distributed RAM: write port (A/D/WE) plus read port (DPRA/DPO).
interface dram_fill_check_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ram_a;
   logic              ram_d;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_dpra;
   logic              ram_dpo;

   modport master (
      output ram_a,
      output ram_d,
      output ram_we,
      output ram_dpra,
      input  ram_dpo
   );

   modport slave (
      input  ram_a,
      input  ram_d,
      input  ram_we,
      input  ram_dpra,
      output ram_dpo
   );
endinterface

// File: rtl/dram_fill_check.sv
// Fills every cell of an external dual-port distributed RAM with a selected
// pattern, sweeps the read port comparing DPO, and reports pass/error count.
module dram_fill_check #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            pattern_sel,
   dram_fill_check_if.master     bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      err_count
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        sel_q;
   logic              start_run;
   logic [ADDR_W-1:0] a_inc;
   logic              exp_bit;
   logic              mismatch;
   logic [CNT_W-1:0]  err_next;

   // Expected cell value as a function of the pattern selector and address.
   function automatic logic pat(input logic [1:0] sel, input logic [ADDR_W-1:0] addr);
      logic bit_v;
      case (sel)
         2'd0:    bit_v = 1'b0;
         2'd1:    bit_v = 1'b1;
         2'd2:    bit_v = addr[0];
         default: bit_v = ~addr[0];
      endcase
      return bit_v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the per-cycle compare; ram_dpra is registered,
   // so pat(ram_dpra) is already aligned with the DPO it addresses.
   always_comb begin
      state_next = state;
      start_run  = 1'b0;
      a_inc      = bus.ram_a + 1'b1;
      exp_bit    = pat(sel_q, bus.ram_dpra);
      mismatch   = (bus.ram_dpo != exp_bit);
      err_next   = err_count + CNT_W'(mismatch);
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_run  = 1'b1;
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (bus.ram_a == '1) begin
               state_next = READ;
            end
         end
         READ: begin
            if (bus.ram_dpra == '1) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Registered outputs; the RAM captures (ram_a, ram_d) on each edge where
   // ram_we is high, so the last write lands on the edge that leaves WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q        <= 2'd0;
         bus.ram_a    <= '0;
         bus.ram_d    <= 1'b0;
         bus.ram_we   <= 1'b0;
         bus.ram_dpra <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_run) begin
                  sel_q        <= pattern_sel;
                  bus.ram_a    <= '0;
                  bus.ram_d    <= pat(pattern_sel, '0);
                  bus.ram_we   <= 1'b1;
                  bus.ram_dpra <= '0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  pass         <= 1'b0;
                  err_count    <= '0;
               end
            end
            WRITE: begin
               if (bus.ram_a == '1) begin
                  bus.ram_we   <= 1'b0;
                  bus.ram_a    <= '0;
                  bus.ram_d    <= 1'b0;
                  bus.ram_dpra <= '0;
               end else begin
                  bus.ram_a <= a_inc;
                  bus.ram_d <= pat(sel_q, a_inc);
               end
            end
            READ: begin
               err_count    <= err_next;
               bus.ram_dpra <= bus.ram_dpra + 1'b1;
               if (bus.ram_dpra == '1) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_fill_check.sv
// Randomized bench for dram_fill_check with a behavioural RAM32X1D model
// (optionally faulted) and a reference error count derived from the pattern.
module tb_dram_fill_check;

   localparam int ADDR_W = 5;
   localparam int CNT_W  = 6;
   localparam int DEPTH  = 1 << ADDR_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       pattern_sel = 2'd0;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;

   int vectors = 0;
   int miscompares = 0;
   int we_viol = 0;

   // Fault modes: 0 good RAM, 1 one address reads stuck-at-0, 2 DPO inverted.
   int         fault_mode = 0;
   int         fault_addr = 0;
   logic       mem [DEPTH];
   logic       dpo_model;

   dram_fill_check_if #(.ADDR_W(ADDR_W)) ram_if ();

   dram_fill_check #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pattern_sel (pattern_sel),
      .bus         (ram_if),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_if.ram_we) mem[ram_if.ram_a] <= ram_if.ram_d;
   end

   always_comb begin
      dpo_model = mem[ram_if.ram_dpra];
      if (fault_mode == 1 && int'(ram_if.ram_dpra) == fault_addr) dpo_model = 1'b0;
      if (fault_mode == 2) dpo_model = ~mem[ram_if.ram_dpra];
   end
   assign ram_if.ram_dpo = dpo_model;

   always @(negedge clk) begin
      if (rst_n && ram_if.ram_we && !busy) we_viol++;
   end

   function automatic logic pat_bit(input int sel, input int addr);
      case (sel)
         0: return 1'b0;
         1: return 1'b1;
         2: return 1'((addr % 2) == 1);
         default: return 1'((addr % 2) == 0);
      endcase
   endfunction

   // Reference: every cell holds pat(k); count reads the fault turns wrong.
   function automatic int ref_errors(input int sel, input int fmode, input int faddr);
      int n = 0;
      for (int k = 0; k < DEPTH; k++) begin
         logic stored = pat_bit(sel, k);
         logic rd = stored;
         if (fmode == 1 && k == faddr) rd = 1'b0;
         if (fmode == 2) rd = ~stored;
         if (rd != pat_bit(sel, k)) n++;
      end
      return n;
   endfunction

   // Drive start at a negedge, return #1 after the start edge E0.
   task automatic launch(input int sel, input bit hold);
      @(negedge clk);
      pattern_sel = 2'(sel);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Count edges from the caller's current edge until done is seen.
   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 150; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, pass, err_count, ram_if.ram_a, ram_if.ram_d, ram_if.ram_we, ram_if.ram_dpra} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_hold: outputs=%b required all 0",
                  {busy, done, pass, err_count, ram_if.ram_a, ram_if.ram_d, ram_if.ram_we, ram_if.ram_dpra});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, pass, err_count, ram_if.ram_we} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle: busy=%b done=%b pass=%b err=%0d we=%b required all 0",
                  busy, done, pass, err_count, ram_if.ram_we);
      end
      launch(2, 1'b0);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ram_if.ram_we !== 1'b0 || busy !== 1'b0 || ram_if.ram_a !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_write: we=%b busy=%b a=%0d required 0 0 0",
                  ram_if.ram_we, busy, ram_if.ram_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_good_fill;
      int lat;
      int bad = 0;
      fault_mode = 0;
      launch(2, 1'b0);
      wait_done(lat);
      vectors++;
      if (lat !== 64) begin
         miscompares++;
         $display("[TB] FAIL good_latency: got %0d required 64", lat);
      end
      vectors++;
      if (pass !== 1'b1 || err_count !== '0) begin
         miscompares++;
         $display("[TB] FAIL good_result: pass=%b err=%0d required 1 0", pass, err_count);
      end
      for (int k = 0; k < DEPTH; k++) if (mem[k] !== pat_bit(2, k)) bad++;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("[TB] FAIL good_contents: %0d bad cells required 0", bad);
      end
   endtask

   task automatic test_stuck_bit;
      int lat;
      fault_mode = 1;
      fault_addr = 5;
      launch(1, 1'b0);
      wait_done(lat);
      vectors++;
      if (lat !== 64 || pass !== 1'b0 || err_count !== CNT_W'(1)) begin
         miscompares++;
         $display("[TB] FAIL stuck_bit: lat=%0d pass=%b err=%0d required 64 0 1", lat, pass, err_count);
      end
      fault_mode = 0;
   endtask

   task automatic test_inverted;
      int lat;
      fault_mode = 2;
      launch(0, 1'b0);
      wait_done(lat);
      vectors++;
      if (lat !== 64 || pass !== 1'b0 || err_count !== 6'b100000) begin
         miscompares++;
         $display("[TB] FAIL inverted: lat=%0d pass=%b err=%0d required 64 0 32", lat, pass, err_count);
      end
      fault_mode = 0;
   endtask

   task automatic test_back_to_back;
      int lat = -1;
      fault_mode = 2;
      launch(3, 1'b0);
      for (int i = 1; i <= 150; i++) begin
         @(posedge clk);
         #1;
         if (i >= 36 && i <= 45) start = (i % 2 == 0);
         if (i == 46) start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      vectors++;
      if (lat !== 64 || err_count !== CNT_W'(32)) begin
         miscompares++;
         $display("[TB] FAIL toggle_in_read: lat=%0d err=%0d required 64 32", lat, err_count);
      end
      pattern_sel = 2'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      fault_mode = 0;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || err_count !== '0 || ram_if.ram_we !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rearm: busy=%b done=%b err=%0d we=%b required 1 0 0 1",
                  busy, done, err_count, ram_if.ram_we);
      end
      start = 1'b0;
      wait_done(lat);
      vectors++;
      if (lat !== 64 || pass !== 1'b1 || err_count !== '0) begin
         miscompares++;
         $display("[TB] FAIL second_run: lat=%0d pass=%b err=%0d required 64 1 0", lat, pass, err_count);
      end
   endtask

   task automatic test_reset_mid_read;
      int lat;
      fault_mode = 2;
      launch(1, 1'b0);
      repeat (45) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || err_count !== '0 || ram_if.ram_dpra !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_read: busy=%b err=%0d dpra=%0d required 0 0 0",
                  busy, err_count, ram_if.ram_dpra);
      end
      @(negedge clk);
      rst_n = 1'b1;
      fault_mode = 0;
      launch(3, 1'b0);
      wait_done(lat);
      vectors++;
      if (lat !== 64 || pass !== 1'b1 || err_count !== '0) begin
         miscompares++;
         $display("[TB] FAIL clean_after_reset: lat=%0d pass=%b err=%0d required 64 1 0", lat, pass, err_count);
      end
   endtask

   task automatic test_random;
      int lat;
      int sel;
      int exp_err;
      for (int r = 0; r < 8; r++) begin
         sel = int'($urandom_range(3, 0));
         fault_addr = int'($urandom_range(DEPTH - 1, 0));
         fault_mode = int'($urandom_range(2, 0));
         exp_err = ref_errors(sel, fault_mode, fault_addr);
         launch(sel, 1'b0);
         wait_done(lat);
         vectors++;
         if (lat !== 64 || int'(err_count) !== exp_err || pass !== (exp_err == 0)) begin
            miscompares++;
            $display("[TB] FAIL random_run%0d: sel=%0d fault=%0d@%0d lat=%0d err=%0d pass=%b required 64 %0d %b",
                     r, sel, fault_mode, fault_addr, lat, err_count, pass, exp_err, exp_err == 0);
         end
      end
      fault_mode = 0;
      vectors++;
      if (we_viol !== 0) begin
         miscompares++;
         $display("[TB] FAIL we_outside_busy: %0d cycles required 0", we_viol);
      end
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) mem[k] = 1'b0;
      test_reset;
      test_good_fill;
      test_stuck_bit;
      test_inverted;
      test_back_to_back;
      test_reset_mid_read;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
